mem_port_arbiter: RTL and testbench

Arbitrates the single memory port (`memory` module's dmem-side address/data/write-enable/funct3 interface) between two requesters: the instruction-fetch unit and the load/store unit. Grants one access per cycle, routes read data back to the owning requester through a latency-matched tag pipeline, and guarantees fetch forward progress with a starvation counter. Sits between the core's fetch/LSU logic and `memory`, replacing direct wiring of the dmem port.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester (fetch/LSU) arbiter for the single dmem port with tagged read return
module mem_port_arbiter #(
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        mem_wren,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,

    output logic        busy
);

    localparam logic [3:0] STARVE_THRESH = 4'(STARVE_LIMIT);
    localparam logic [2:0] FUNCT3_WORD   = 3'b010;

    logic [3:0]              starve_cnt;
    // One {valid, owner} pair per cycle of memory latency; owner 1 = LSU.
    logic [READ_LATENCY-1:0] tag_valid;
    logic [READ_LATENCY-1:0] tag_owner;

    logic fetch_win;
    logic lsu_win;
    logic read_grant;

    // LSU normally has priority; fetch takes over once it has been
    // denied STARVE_LIMIT consecutive cycles.
    always_comb begin
        fetch_win  = f_req && (!d_req || (starve_cnt >= STARVE_THRESH));
        lsu_win    = d_req && !fetch_win;
        read_grant = fetch_win || (lsu_win && !d_we);
    end

    assign f_gnt = fetch_win;
    assign d_gnt = lsu_win;

    always_comb begin
        mem_wren    = 1'b0;
        mem_funct3  = FUNCT3_WORD;
        mem_address = 32'h0;
        mem_data_in = 32'h0;
        if (fetch_win) begin
            mem_address = f_addr;
        end else if (lsu_win) begin
            mem_wren    = d_we;
            mem_funct3  = d_funct3;
            mem_address = d_addr;
            mem_data_in = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_valid  <= '0;
            tag_owner  <= '0;
            starve_cnt <= 4'd0;
        end else begin
            tag_valid[0] <= read_grant;
            tag_owner[0] <= lsu_win;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end

            if (f_req && !fetch_win) begin
                if (starve_cnt != 4'hF) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
        end
    end

    // The final tag stage lines up with the cycle mem_data_out carries
    // the data for the read it describes.
    always_comb begin
        f_rvalid = tag_valid[READ_LATENCY-1] && !tag_owner[READ_LATENCY-1];
        d_rvalid = tag_valid[READ_LATENCY-1] &&  tag_owner[READ_LATENCY-1];
        f_rdata  = f_rvalid ? mem_data_out : 32'h0;
        d_rdata  = d_rvalid ? mem_data_out : 32'h0;
        busy     = |tag_valid;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int RL    = 3;
    localparam int SL    = 4;
    localparam int NCYC  = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'h0;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_funct3 = 3'b010;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_wren;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        busy;

    mem_port_arbiter #(.READ_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_wren(mem_wren), .mem_funct3(mem_funct3), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input logic [29:0] wa);
        return (32'({2'b00, wa}) * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory stand-in: word-addressed, fixed READ_LATENCY read pipe.
    logic [31:0] env_mem [logic [29:0]];
    logic [31:0] rd_pipe [RL];

    function automatic logic [31:0] env_read(input logic [29:0] wa);
        return env_mem.exists(wa) ? env_mem[wa] : seed_word(wa);
    endfunction

    always @(posedge clk) begin
        if (mem_wren) env_mem[mem_address[31:2]] = mem_data_in;
        rd_pipe[0] <= env_read(mem_address[31:2]);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_data_out = rd_pipe[RL-1];

    // Reference model state
    logic [31:0] ref_mem [logic [29:0]];
    int          exp_owner [NCYC];   // 0 none, 1 fetch, 2 LSU
    logic [31:0] exp_data  [NCYC];
    int          denied_run = 0;
    bit          armed = 0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [31:0] ref_read(input logic [29:0] wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : seed_word(wa);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic run_cycle(input logic rst, input logic fr, input logic [31:0] fa,
                             input logic dr, input logic dwe, input logic [2:0] df3,
                             input logic [31:0] da, input logic [31:0] dwd);
        logic ef, ed, ew, eb;
        logic [31:0] ea, edi;
        logic [2:0] ef3;
        reset = rst; f_req = fr; f_addr = fa;
        d_req = dr; d_we = dwe; d_funct3 = df3; d_addr = da; d_wdata = dwd;
        #1;
        ef = fr && (!dr || denied_run >= SL);
        ed = dr && !ef;
        ew = 1'b0; ef3 = 3'b010; ea = 32'h0; edi = 32'h0;
        if (ef) begin
            ea = fa;
        end else if (ed) begin
            ew = dwe; ef3 = df3; ea = da; edi = dwd;
        end
        check("f_gnt", 32'(f_gnt), 32'(ef));
        check("d_gnt", 32'(d_gnt), 32'(ed));
        check("mem_address", mem_address, ea);
        check("mem_wren", 32'(mem_wren), 32'(ew));
        check("mem_funct3", 32'(mem_funct3), 32'(ef3));
        check("mem_data_in", mem_data_in, edi);
        if (armed) begin
            check("f_rvalid", 32'(f_rvalid), 32'(exp_owner[cyc] == 1));
            check("d_rvalid", 32'(d_rvalid), 32'(exp_owner[cyc] == 2));
            check("f_rdata", f_rdata, (exp_owner[cyc] == 1) ? exp_data[cyc] : 32'h0);
            check("d_rdata", d_rdata, (exp_owner[cyc] == 2) ? exp_data[cyc] : 32'h0);
            eb = 1'b0;
            for (int k = 0; k < RL; k++) if (exp_owner[cyc+k] != 0) eb = 1'b1;
            check("busy", 32'(busy), 32'(eb));
        end
        @(posedge clk);
        if (!rst) begin
            for (int k = 1; k <= RL; k++) exp_owner[cyc+k] = 0;
            denied_run = 0;
            armed = 1;
        end else begin
            if (ef) begin
                exp_owner[cyc+RL] = 1;
                exp_data[cyc+RL]  = ref_read(fa[31:2]);
            end else if (ed && !dwe) begin
                exp_owner[cyc+RL] = 2;
                exp_data[cyc+RL]  = ref_read(da[31:2]);
            end
            denied_run = (fr && !ef) ? ((denied_run < 15) ? denied_run + 1 : 15) : 0;
        end
        if (ed && dwe) ref_mem[da[31:2]] = dwd;
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1, 0, 0, 0, 0, 3'b010, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_owner[i] = 0;
            exp_data[i]  = 32'h0;
        end
        @(posedge clk); #1;

        // Reset with no traffic, then reset with reads in flight.
        run_cycle(0, 0, 0, 0, 0, 3'b010, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 3'b010, 0, 0);
        run_cycle(1, 1, 32'h0000_0100, 0, 0, 3'b010, 0, 0);
        run_cycle(1, 0, 0, 1, 0, 3'b010, 32'h0000_0200, 0);
        run_cycle(0, 1, 32'h0000_0104, 1, 0, 3'b010, 32'h0000_0204, 0);
        idle(RL + 2);

        // Solo fetch.
        run_cycle(1, 1, 32'h0000_1000, 0, 0, 3'b010, 0, 0);
        idle(RL + 1);

        // Continuous contention: LSU x4, fetch, LSU x4, fetch.
        for (int i = 0; i < 12; i++)
            run_cycle(1, 1, 32'h0000_1100 + 32'(i*4), 1, 0, 3'b010, 32'h0000_1200 + 32'(i*4), 0);
        idle(RL + 1);

        // LSU write then readback.
        run_cycle(1, 0, 0, 1, 1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF);
        idle(2);
        run_cycle(1, 0, 0, 1, 0, 3'b010, 32'h0000_2000, 0);
        idle(RL + 1);

        // Pipelined alternating owners.
        run_cycle(1, 1, 32'h0000_1000, 0, 0, 3'b010, 0, 0);
        run_cycle(1, 0, 0, 1, 0, 3'b010, 32'h0000_2000, 0);
        run_cycle(1, 1, 32'h0000_1004, 0, 0, 3'b010, 0, 0);
        idle(RL + 2);

        // Withdrawn fetch request after building up denial, then contention again.
        for (int i = 0; i < 3; i++)
            run_cycle(1, 1, 32'h0000_1500, 1, 0, 3'b010, 32'h0000_1600 + 32'(i*4), 0);
        run_cycle(1, 0, 0, 1, 0, 3'b010, 32'h0000_1610, 0);
        for (int i = 0; i < 6; i++)
            run_cycle(1, 1, 32'h0000_1500, 1, 1, 3'b000, 32'h0000_1700 + 32'(i*4), 32'(i));
        idle(RL + 1);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            logic rst, fr, dr, dwe;
            rst = ($urandom_range(0, 59) != 0);
            fr  = ($urandom_range(0, 9) < 6);
            dr  = ($urandom_range(0, 9) < 7);
            dwe = ($urandom_range(0, 9) < 3);
            run_cycle(rst, fr, 32'h0000_3000 + 32'($urandom_range(0, 15) * 4),
                      dr, dwe, 3'($urandom_range(0, 7)),
                      32'h0000_3000 + 32'($urandom_range(0, 15) * 4), $urandom);
        end
        idle(RL + 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
